// File: rtl/dr_alm_accum.sv
// dr_alm_accum: accumulates signed product beats from the approximate log
// multiplier into dot-product sums. Each finished sum is held for the consumer
// with a valid/ready handshake.
//
// Optional build macro DR_ALM_ACCUM_SAT_EN: when defined, an overflowing sum
// clamps to the signed limit in the overflow direction and stays there for the
// rest of the vector. When undefined, the sum wraps (two's complement).
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no partial sum; the next accepted beat starts a new vector
// S_ACCUM | partial sum in progress, waiting for the last beat
// S_HOLD  | finished result on o_acc, o_acc_valid=1 until it is drained
module dr_alm_accum #(
    parameter  int WIDTH     = 16,
    parameter  int ACC_WIDTH = 40,
    parameter  int MAX_LEN   = 256,
    localparam int CW        = $clog2(MAX_LEN + 1)
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_clear,
    input  logic                        i_prod_valid,
    output logic                        o_prod_ready,
    input  logic signed [2*WIDTH-1:0]   i_prod,
    input  logic                        i_prod_last,
    output logic                        o_acc_valid,
    input  logic                        i_acc_ready,
    output logic signed [ACC_WIDTH-1:0] o_acc,
    output logic [CW-1:0]               o_acc_count,
    output logic                        o_acc_ovf,
    output logic                        o_acc_trunc
);

    // Parameter sanity: the accumulator must hold a full product, and a
    // vector must be allowed at least one term.
    if (ACC_WIDTH < 2 * WIDTH) begin : g_bad_acc_width
        $error("dr_alm_accum: ACC_WIDTH must be >= 2*WIDTH");
    end
    if (MAX_LEN < 1) begin : g_bad_max_len
        $error("dr_alm_accum: MAX_LEN must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LEN);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    state_t                       state_q, state_d;
    logic signed [ACC_WIDTH-1:0]  sum_q, sum_d;
    logic [CW-1:0]                count_q, count_d;
    logic                         ovf_q, ovf_d;
    logic                         trunc_q, trunc_d;

    logic                         prod_ready;
    logic                         accept;
    logic                         start_new;
    logic                         at_max;
    logic [CW-1:0]                cnt_next;
    logic signed [ACC_WIDTH-1:0]  prod_ext;
    logic signed [ACC_WIDTH-1:0]  sum_add;
    logic signed [ACC_WIDTH-1:0]  acc_next;
    logic                         add_ovf;

    // Datapath for one accumulate step: sign-extended add, overflow test and
    // the wrap/saturate choice for the sum that follows.
    always_comb begin
        prod_ext = ACC_WIDTH'(i_prod);
        sum_add  = sum_q + prod_ext;
        add_ovf  = (sum_q[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                   (sum_add[ACC_WIDTH-1] != sum_q[ACC_WIDTH-1]);
`ifdef DR_ALM_ACCUM_SAT_EN
        // Once a vector has overflowed the sum sits on the clamp value; the
        // sticky flag doubles as the "already clamped" marker.
        if (ovf_q) begin
            acc_next = sum_q;
        end else if (add_ovf) begin
            acc_next = sum_q[ACC_WIDTH-1] ? SAT_MIN : SAT_MAX;
        end else begin
            acc_next = sum_add;
        end
`else
        acc_next = sum_add;
`endif
    end

    // A held result blocks new beats only while the consumer is stalling,
    // so a drain and the first beat of the next vector share one cycle.
    assign prod_ready   = (state_q != S_HOLD) || i_acc_ready;
    assign o_prod_ready = prod_ready;
    assign accept       = i_prod_valid && prod_ready;
    assign start_new    = (state_q == S_IDLE) || (state_q == S_HOLD);
    assign cnt_next     = start_new ? CW'(1) : count_q + CW'(1);
    assign at_max       = (cnt_next == MAX_CNT);

    // Next-state logic: clear beats everything, then beat acceptance, then drain.
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        trunc_d = trunc_q;
        if (i_clear) begin
            state_d = S_IDLE;
            sum_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            trunc_d = 1'b0;
        end else if (accept) begin
            if (start_new) begin
                sum_d = prod_ext;
                ovf_d = 1'b0;
            end else begin
                sum_d = acc_next;
                ovf_d = ovf_q | add_ovf;
            end
            count_d = cnt_next;
            trunc_d = at_max && !i_prod_last;
            state_d = (i_prod_last || at_max) ? S_HOLD : S_ACCUM;
        end else if ((state_q == S_HOLD) && i_acc_ready) begin
            state_d = S_IDLE;
        end
    end

    // State and accumulator registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            sum_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            trunc_q <= trunc_d;
        end
    end

    // The accumulator registers double as the result holding register: the
    // sum is only reused by a new vector once the held result has drained.
    assign o_acc_valid = (state_q == S_HOLD);
    assign o_acc       = sum_q;
    assign o_acc_count = count_q;
    assign o_acc_ovf   = ovf_q;
    assign o_acc_trunc = trunc_q;

endmodule

// File: tb/tb_dr_alm_accum.sv
// Directed bench for dr_alm_accum (WIDTH=16, ACC_WIDTH=32, MAX_LEN=4).
module tb_dr_alm_accum;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        prod_valid;
    logic        prod_ready;
    logic [31:0] prod;
    logic        prod_last;
    logic        acc_valid;
    logic        acc_ready;
    logic [31:0] acc;
    logic [2:0]  acc_count;
    logic        acc_ovf;
    logic        acc_trunc;

    int tests = 0;
    int fails = 0;

    dr_alm_accum #(
        .WIDTH    (16),
        .ACC_WIDTH(32),
        .MAX_LEN  (4)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_clear     (clear),
        .i_prod_valid(prod_valid),
        .o_prod_ready(prod_ready),
        .i_prod      (prod),
        .i_prod_last (prod_last),
        .o_acc_valid (acc_valid),
        .i_acc_ready (acc_ready),
        .o_acc       (acc),
        .o_acc_count (acc_count),
        .o_acc_ovf   (acc_ovf),
        .o_acc_trunc (acc_trunc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat for exactly one clock edge, then sample 1 ns later.
    task automatic beat(input logic [31:0] v, input logic last);
        prod_valid = 1'b1;
        prod       = v;
        prod_last  = last;
        step();
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        prod       = '0;
    endtask

    task automatic chk_result(input string tag, input logic [31:0] exp_acc,
                              input int exp_cnt, input logic exp_ovf, input logic exp_trunc);
        chk({tag, ".valid"}, 32'(acc_valid), 1);
        chk({tag, ".acc"},   acc, exp_acc);
        chk({tag, ".count"}, 32'(acc_count), exp_cnt);
        chk({tag, ".ovf"},   32'(acc_ovf), 32'(exp_ovf));
        chk({tag, ".trunc"}, 32'(acc_trunc), 32'(exp_trunc));
    endtask

    initial begin
        rst_n      = 1'b0;
        clear      = 1'b0;
        prod_valid = 1'b0;
        prod       = '0;
        prod_last  = 1'b0;
        acc_ready  = 1'b1;

        // Reset state
        #12;
        chk("rst.valid", 32'(acc_valid), 0);
        chk("rst.acc",   acc, 0);
        chk("rst.count", 32'(acc_count), 0);
        chk("rst.ovf",   32'(acc_ovf), 0);
        chk("rst.trunc", 32'(acc_trunc), 0);
        chk("rst.ready", 32'(prod_ready), 1);
        rst_n = 1'b1;
        step();

        // Basic vector 100, -30, 7 -> 77, valid for exactly one cycle
        beat(32'd100, 1'b0);
        beat(-32'sd30, 1'b0);
        chk("basic.pre_valid", 32'(acc_valid), 0);
        beat(32'd7, 1'b1);
        chk_result("basic", 32'd77, 3, 1'b0, 1'b0);
        step();
        chk("basic.one_cycle", 32'(acc_valid), 0);

        // Backpressure: -5 held for 5 stalled cycles
        acc_ready = 1'b0;
        beat(-32'sd5, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("bp.valid", 32'(acc_valid), 1);
            chk("bp.acc",   acc, 32'hFFFF_FFFB);
            chk("bp.ready", 32'(prod_ready), 0);
            step();
        end
        acc_ready = 1'b1;
        #1;
        chk("bp.ready_up", 32'(prod_ready), 1);
        beat(32'd9, 1'b1);
        chk_result("bp.next", 32'd9, 1, 1'b0, 1'b0);
        step();
        chk("bp.drained", 32'(acc_valid), 0);

        // Overflow: 0x40000000 + 0x40000000
        beat(32'h4000_0000, 1'b0);
        beat(32'h4000_0000, 1'b1);
`ifdef DR_ALM_ACCUM_SAT_EN
        chk_result("ovf2", 32'h7FFF_FFFF, 2, 1'b1, 1'b0);
`else
        chk_result("ovf2", 32'h8000_0000, 2, 1'b1, 1'b0);
`endif
        // Same vector followed by -1 (drains the previous result in the same cycle)
        beat(32'h4000_0000, 1'b0);
        beat(32'h4000_0000, 1'b0);
        beat(32'hFFFF_FFFF, 1'b1);
        chk_result("ovf3", 32'h7FFF_FFFF, 3, 1'b1, 1'b0);
        step();

        // Truncation at MAX_LEN=4, then a fresh vector clears the flag
        beat(32'd1, 1'b0);
        beat(32'd2, 1'b0);
        beat(32'd3, 1'b0);
        chk("trunc.pre_valid", 32'(acc_valid), 0);
        beat(32'd4, 1'b0);
        chk_result("trunc", 32'd10, 4, 1'b0, 1'b1);
        beat(32'd5, 1'b1);
        chk_result("trunc.next", 32'd5, 1, 1'b0, 1'b0);
        step();

        // Clear drops the partial sum 10+20
        beat(32'd10, 1'b0);
        beat(32'd20, 1'b0);
        chk("clr.partial", acc, 32'd30);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr.valid", 32'(acc_valid), 0);
        chk("clr.acc",   acc, 0);
        chk("clr.count", 32'(acc_count), 0);
        beat(32'd3, 1'b1);
        chk_result("clr.after", 32'd3, 1, 1'b0, 1'b0);
        // Clear while holding a stalled result
        acc_ready = 1'b0;
        clear     = 1'b1;
        step();
        clear = 1'b0;
        chk("clr.hold_valid", 32'(acc_valid), 0);
        chk("clr.hold_acc",   acc, 0);
        // Clear drops a beat presented in the same cycle; ready unaffected
        acc_ready = 1'b1;
        clear     = 1'b1;
        #1;
        chk("clr.ready", 32'(prod_ready), 1);
        beat(32'd7, 1'b1);
        clear = 1'b0;
        chk("clr.drop_valid", 32'(acc_valid), 0);
        chk("clr.drop_count", 32'(acc_count), 0);

        // Asynchronous reset mid-vector
        beat(32'd2, 1'b0);
        beat(32'd2, 1'b0);
        chk("arst.partial", acc, 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.valid", 32'(acc_valid), 0);
        chk("arst.acc",   acc, 0);
        chk("arst.count", 32'(acc_count), 0);
        #2;
        rst_n = 1'b1;
        step();
        beat(32'd2, 1'b0);
        beat(32'd2, 1'b1);
        chk_result("arst.after", 32'd4, 2, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
